multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I datapath: fetch, decode, execute, memory and writeback.

---
 rtl/multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle control FSM (fetch/decode/execute/mem/writeback)
// Optional macro CTRL_ILLEGAL_TRAP_EN adds the ILLEGAL trap state and the illegal output.
module multicycle_ctrl #(
  parameter int USE_MEM_READY = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opecode,
  input  logic [2:0]       f3,
  input  logic             f7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcWrite,
  output logic             adrSrc,
  output logic             irWrite,
  output logic             memWrite,
  output logic             regWrite,
  output logic [1:0]       resultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       inmSrc,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mem_rdy;
  logic             is_store;
  logic             retire;
  logic             pc_we, ir_we, mem_we, reg_we;

  assign mem_rdy  = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign is_store = (opecode == 7'b0100011);

  // f7 only selects sub for register-register ops; immediates never carry it.
  function automatic logic [2:0] funct_alu(input logic [2:0] fn3, input logic fn7,
                                           input logic is_r);
    case (fn3)
      3'b000:  funct_alu = (is_r && fn7) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    adrSrc     = 1'b0;
    resultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    inmSrc     = 2'b00;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        resultSrc = 2'b10;
        ir_we     = mem_rdy;
        pc_we     = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        inmSrc  = 2'b10;
        case (opecode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                state_d = S_ILLEGAL;
`else
          default:                state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        inmSrc  = is_store ? 2'b01 : 2'b00;
        state_d = is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        reg_we    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc = 1'b1;
        mem_we = 1'b1;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu(f3, f7, 1'b1);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu(f3, f7, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        inmSrc     = 2'b10;
        pc_we      = zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        inmSrc  = 2'b11;
        state_d = S_ALUWB;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_ILLEGAL;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  // Strobes are masked by rst directly so an abandoned access cannot write while held in reset.
  assign pcWrite  = pc_we  & ~rst;
  assign irWrite  = ir_we  & ~rst;
  assign memWrite = mem_we & ~rst;
  assign regWrite = reg_we & ~rst;
  assign state    = state_q;
  assign instret  = instret_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized instruction-stream bench for multicycle_ctrl
// Expected cycles are expanded per instruction class; outputs checked every cycle.
module tb_multicycle_ctrl;
  logic        clk, rst;
  logic [6:0]  opecode;
  logic [2:0]  f3;
  logic        f7, zero, mem_ready;
  logic        pcWrite, adrSrc, irWrite, memWrite, regWrite;
  logic [1:0]  resultSrc, ALUSrcA, ALUSrcB, inmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state;
  logic [31:0] instret;
  logic [15:0] act_ctl;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  multicycle_ctrl #(.USE_MEM_READY(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opecode(opecode), .f3(f3), .f7(f7), .zero(zero),
    .mem_ready(mem_ready), .pcWrite(pcWrite), .adrSrc(adrSrc), .irWrite(irWrite),
    .memWrite(memWrite), .regWrite(regWrite), .resultSrc(resultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .inmSrc(inmSrc), .state(state),
    .instret(instret)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  assign act_ctl = {pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, inmSrc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_cnt = 0;
  logic [6:0]  cur_op = 0;
  logic [2:0]  cur_f3 = 0;
  logic        cur_f7 = 0, cur_zero = 0, cur_sw = 0;
  int          ncyc, mw_cycles;
  logic [2:0]  seen_alu;
  logic        seen_pcw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_alu(input logic is_r);
    case (cur_f3)
      3'd0:    return (is_r && cur_f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Control word the state table prescribes for each state number.
  function automatic logic [15:0] exp_ctl(input int st, input logic mr);
    logic pw, ad, ir, mw, rw;
    logic [1:0] rs, a, b, im;
    logic [2:0] al;
    {pw, ad, ir, mw, rw} = '0;
    rs = 0; a = 0; b = 0; im = 0; al = 0;
    case (st)
      0:  begin b = 2; rs = 2; ir = mr; pw = mr; end
      1:  begin a = 1; b = 1; im = 2; end
      2:  begin a = 2; b = 1; im = cur_sw ? 2'd1 : 2'd0; end
      3:  ad = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin ad = 1; mw = 1; end
      6:  begin a = 2; al = ref_alu(1'b1); end
      7:  begin a = 2; b = 1; al = ref_alu(1'b0); end
      8:  rw = 1;
      9:  begin a = 2; al = 3'b001; pw = cur_zero; im = 2; end
      10: begin a = 1; b = 2; pw = 1; im = 3; end
      default: ;
    endcase
    return {pw, ad, ir, mw, rw, rs, a, b, al, im};
  endfunction

  task automatic cyc(input int st, input logic mr);
    logic [15:0] e;
    @(posedge clk); #1;
    mem_ready = mr; opecode = cur_op; f3 = cur_f3; f7 = cur_f7; zero = cur_zero;
    e = exp_ctl(st, mr);
    @(negedge clk);
    chk("state", {28'd0, state}, st);
    chk("ctl", {16'd0, act_ctl}, {16'd0, e});
    chk("instret", instret, model_cnt);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal", {31'd0, illegal}, (st == 11) ? 32'd1 : 32'd0);
`endif
    if (st == 6 || st == 7) seen_alu = ALUControl;
    if (st == 9) seen_pcw = pcWrite;
    if (memWrite) mw_cycles++;
    ncyc++;
    if (st == 4 || st == 8 || st == 9 || (st == 5 && mr)) model_cnt++;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] opc(input int kind);
    case (kind)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 unknown opcode
  task automatic run_instr(input int kind, input logic [2:0] fn3, input logic fn7,
                           input logic z, input int fw, input int mw);
    cur_op = opc(kind); cur_f3 = fn3; cur_f7 = fn7; cur_zero = z; cur_sw = (kind == 1);
    ncyc = 0; mw_cycles = 0;
    for (int i = 0; i < fw; i++) cyc(0, 1'b0);
    cyc(0, 1'b1);
    cyc(1, rb());
    case (kind)
      0: begin
        cyc(2, rb());
        for (int i = 0; i < mw; i++) cyc(3, 1'b0);
        cyc(3, 1'b1);
        cyc(4, rb());
      end
      1: begin
        cyc(2, rb());
        for (int i = 0; i < mw; i++) cyc(5, 1'b0);
        cyc(5, 1'b1);
      end
      2: begin cyc(6, rb()); cyc(8, rb()); end
      3: begin cyc(7, rb()); cyc(8, rb()); end
      4: cyc(9, rb());
      5: begin cyc(10, rb()); cyc(8, rb()); end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    #2 rst = 1'b1; mem_ready = 1'b1;
    #1;
    chk("rst_memWrite", {31'd0, memWrite}, 0);
    chk("rst_irWrite", {31'd0, irWrite}, 0);
    chk("rst_pcWrite", {31'd0, pcWrite}, 0);
    chk("rst_state", {28'd0, state}, 0);
    chk("rst_instret", instret, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    model_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opecode = 0; f3 = 0; f7 = 0; zero = 0;
    #2;
    chk("reset_state", {28'd0, state}, 0);
    chk("reset_instret", instret, 0);
    chk("reset_irWrite", {31'd0, irWrite}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;

    run_instr(0, 3'b010, 1'b0, 1'b0, 0, 0);
    chk("lw_cpi", ncyc, 5);
    chk("lw_memwb_regWrite", {31'd0, regWrite}, 1);
    chk("lw_memwb_resultSrc", {30'd0, resultSrc}, 32'd1);
    run_instr(1, 3'b010, 1'b0, 1'b0, 0, 3);
    chk("sw_memWrite_cycles", mw_cycles, 4);
    chk("sw_cycles", ncyc, 7);
    run_instr(2, 3'b000, 1'b1, 1'b0, 0, 0);
    chk("sub_alu", {29'd0, seen_alu}, 32'b001);
    chk("r_cpi", ncyc, 4);
    run_instr(2, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("add_alu", {29'd0, seen_alu}, 32'b000);
    run_instr(2, 3'b010, 1'b0, 1'b0, 0, 0);
    chk("slt_alu", {29'd0, seen_alu}, 32'b101);
    run_instr(3, 3'b000, 1'b1, 1'b0, 0, 0);
    chk("addi_f7_alu", {29'd0, seen_alu}, 32'b000);
    chk("i_cpi", ncyc, 4);
    run_instr(4, 3'b000, 1'b0, 1'b1, 0, 0);
    chk("beq_taken_pcw", {31'd0, seen_pcw}, 1);
    chk("beq_cpi", ncyc, 3);
    run_instr(4, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("beq_not_taken_pcw", {31'd0, seen_pcw}, 0);
    chk("beq_cpi2", ncyc, 3);
    run_instr(5, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("jal_cpi", ncyc, 4);
`ifndef CTRL_ILLEGAL_TRAP_EN
    run_instr(6, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("unknown_cycles", ncyc, 2);
`endif
    chk("model_retired", model_cnt, 9);

    // Reset while a store waits on memory.
    cur_op = opc(1); cur_f3 = 3'b010; cur_f7 = 0; cur_zero = 0; cur_sw = 1;
    cyc(0, 1'b1); cyc(1, 1'b1); cyc(2, 1'b1); cyc(5, 1'b0); cyc(5, 1'b0);
    chk("pre_rst_memWrite", {31'd0, memWrite}, 1);
    do_reset();

    for (int n = 0; n < 250; n++)
      run_instr($urandom_range(0, 5), 3'($urandom_range(0, 7)), rb(), rb(),
                $urandom_range(0, 2), $urandom_range(0, 3));

`ifdef CTRL_ILLEGAL_TRAP_EN
    cur_op = 7'b0000000; cur_f3 = 0; cur_f7 = 0; cur_zero = 0; cur_sw = 0;
    cyc(0, 1'b1); cyc(1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(11, rb());
    chk("illegal_state", {28'd0, state}, 11);
    chk("illegal_flag", {31'd0, illegal}, 1);
    do_reset();
    chk("illegal_cleared", {31'd0, illegal}, 0);
`endif
    run_instr(2, 3'b111, 1'b0, 1'b0, 1, 0);
    chk("and_alu", {29'd0, seen_alu}, 32'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
